flip_conditioner: RTL and testbench

FLIP_CONDITIONER -- requirements
Module: flip_conditioner

---
 rtl/flip_conditioner_pkg.sv | 16 +
 rtl/flip_conditioner_debounce_channel.sv | 84 ++++++++
 rtl/flip_conditioner.sv | 118 +++++++++++
 tb/tb_flip_conditioner.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/flip_conditioner_pkg.sv
// rtl/flip_conditioner_pkg.sv - shared types and constants for the flip conditioner
// Purpose: channel FSM state enum, event source codes and event FIFO depth.
// Ports: none (package).
package flip_conditioner_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    SETTLE = 1'b1
  } chan_state_e;

  localparam logic SRC_FLIP  = 1'b0;
  localparam logic SRC_INPUT = 1'b1;

  localparam logic [1:0] FIFO_DEPTH = 2'd2;

endpackage

// File: rtl/flip_conditioner_debounce_channel.sv
// rtl/flip_conditioner_debounce_channel.sv - synchroniser, debounce FSM and rise strobe for one input
// Purpose: debounce one asynchronous bouncy input into a clean level plus a one-cycle
//          strobe in the first cycle the level reads 1.
// Ports:
//   clk     - clock, rising edge
//   reset   - synchronous, active-high
//   raw_i   - asynchronous bouncy input
//   level_o - debounced level
//   rise_o  - one-cycle strobe, high in the first cycle after a 0->1 level change
module debounce_channel
  import flip_conditioner_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  // The sample that moves the FSM into SETTLE is the first of the STABLE_CYCLES
  // consecutive differing samples, so the last one arrives at count STABLE_CYCLES-2.
  // Together with the two synchroniser flops this puts the level change exactly
  // STABLE_CYCLES+2 edges after the raw value is first sampled.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 2);

  logic              sync1_q;
  logic              sync2_q;
  chan_state_e       state_q, state_d;
  logic              level_q, level_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rise_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= STABLE;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= level_d & ~level_q;
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    case (state_q)
      STABLE: begin
        if (sync2_q != level_q) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (sync2_q == level_q) begin
          // Input bounced back before it held long enough: glitch rejected.
          state_d = STABLE;
        end else if (cnt_q == CNT_LAST) begin
          level_d = ~level_q;
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = STABLE;
    endcase
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/flip_conditioner.sv
// rtl/flip_conditioner.sv - debounces flip/input sources and queues their rising edges
// Purpose: two debounce channels feed a 2-entry event FIFO; flip wins same-cycle ties.
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous, active-high
//   raw_flip   - asynchronous bouncy flip source
//   raw_input  - asynchronous bouncy data source
//   flip       - debounced raw_flip
//   inputVar   - debounced raw_input
//   evt_valid  - head event present
//   evt_ready  - consumer accepts head event
//   evt_src    - head event source (0 = flip, 1 = inputVar)
//   overflow   - sticky, an event was dropped
module flip_conditioner
  import flip_conditioner_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_flip,
  input  logic raw_input,
  output logic flip,
  output logic inputVar,
  output logic evt_valid,
  input  logic evt_ready,
  output logic evt_src,
  output logic overflow
);

  logic flip_rise;
  logic input_rise;

  debounce_channel #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_flip_chan (
    .clk     (clk),
    .reset   (reset),
    .raw_i   (raw_flip),
    .level_o (flip),
    .rise_o  (flip_rise)
  );

  debounce_channel #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_input_chan (
    .clk     (clk),
    .reset   (reset),
    .raw_i   (raw_input),
    .level_o (inputVar),
    .rise_o  (input_rise)
  );

  // Entry 0 is always the head; entry 1 shifts down on a pop.
  logic [1:0] occ_q, occ_d;
  logic       ent0_q, ent0_d;
  logic       ent1_q, ent1_d;
  logic       ovf_q, ovf_d;
  logic       pop;

  assign evt_valid = (occ_q != 2'd0);
  assign pop       = evt_valid & evt_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q  <= 2'd0;
      ent0_q <= 1'b0;
      ent1_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      ovf_q  <= ovf_d;
    end
  end

  // Pop first so a full FIFO being drained this cycle still takes a push;
  // flip is appended before input so it lands ahead on a same-cycle tie.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    ovf_d  = ovf_q;

    if (pop) begin
      ent0_d = ent1_q;
      occ_d  = occ_q - 2'd1;
    end

    if (flip_rise) begin
      if (occ_d < FIFO_DEPTH) begin
        if (occ_d == 2'd0) ent0_d = SRC_FLIP;
        else               ent1_d = SRC_FLIP;
        occ_d = occ_d + 2'd1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (input_rise) begin
      if (occ_d < FIFO_DEPTH) begin
        if (occ_d == 2'd0) ent0_d = SRC_INPUT;
        else               ent1_d = SRC_INPUT;
        occ_d = occ_d + 2'd1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  assign evt_src  = ent0_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_flip_conditioner.sv
// tb/tb_flip_conditioner.sv - self-checking bench for flip_conditioner
module tb_flip_conditioner;

  localparam int S = 4;

  logic clk;
  logic reset;
  logic raw_flip;
  logic raw_input;
  logic flip;
  logic inputVar;
  logic evt_valid;
  logic evt_ready;
  logic evt_src;
  logic overflow;

  int tests;
  int fails;

  flip_conditioner #(.STABLE_CYCLES(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .raw_flip  (raw_flip),
    .raw_input (raw_input),
    .flip      (flip),
    .inputVar  (inputVar),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_src   (evt_src),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: each input reaches the debouncer two edges late; the level
  // flips once it has disagreed with the synchronised input for S samples in a row.
  // A 0->1 change is offered to the queue on the following edge.
  bit m_ok;
  bit m_s1[2];
  bit m_s2[2];
  bit m_lvl[2];
  int m_run[2];
  bit m_pend[2];
  bit m_ovf;
  bit mq[$];

  task automatic model_step();
    bit raw_now[2];
    raw_now[0] = raw_flip;
    raw_now[1] = raw_input;
    if (reset) begin
      m_ok = 1'b1;
      mq.delete();
      m_ovf = 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
        m_s1[ch] = 1'b0; m_s2[ch] = 1'b0; m_lvl[ch] = 1'b0;
        m_run[ch] = 0; m_pend[ch] = 1'b0;
      end
    end else begin
      if (mq.size() > 0 && evt_ready) void'(mq.pop_front());
      for (int ch = 0; ch < 2; ch++) begin
        if (m_pend[ch]) begin
          if (mq.size() < 2) mq.push_back(ch == 1);
          else m_ovf = 1'b1;
        end
      end
      for (int ch = 0; ch < 2; ch++) begin
        m_pend[ch] = 1'b0;
        if (m_s2[ch] != m_lvl[ch]) begin
          m_run[ch]++;
          if (m_run[ch] == S) begin
            m_lvl[ch] = ~m_lvl[ch];
            m_run[ch] = 0;
            m_pend[ch] = m_lvl[ch];
          end
        end else begin
          m_run[ch] = 0;
        end
        m_s2[ch] = m_s1[ch];
        m_s1[ch] = raw_now[ch];
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_ok) begin
      check("m_flip", flip, m_lvl[0]);
      check("m_inputVar", inputVar, m_lvl[1]);
      check("m_evt_valid", evt_valid, mq.size() > 0);
      check("m_overflow", overflow, m_ovf);
      if (mq.size() > 0) check("m_evt_src", evt_src, mq[0]);
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pop_one();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  task automatic edges_until_flip(output int k);
    k = 0;
    do begin
      tick();
      k++;
    end while (!flip && k < 20);
  endtask

  int k;

  initial begin
    reset = 1'b1; raw_flip = 1'b0; raw_input = 1'b0; evt_ready = 1'b0;
    tests = 0; fails = 0;
    tick(2);
    check("rst_flip", flip, 0);
    check("rst_inputVar", inputVar, 0);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_src", evt_src, 0);
    check("rst_overflow", overflow, 0);

    // Single flip rise, held until consumed.
    reset = 1'b0; raw_flip = 1'b1;
    edges_until_flip(k);
    check("flip_latency", k, 6);
    tick();
    check("s1_valid", evt_valid, 1);
    check("s1_src", evt_src, 0);
    tick(3);
    check("s1_valid_hold", evt_valid, 1);
    pop_one();
    check("s1_valid_drop", evt_valid, 0);

    // Short glitch rejected, pulse of exactly S samples accepted.
    raw_input = 1'b1; tick(3); raw_input = 1'b0; tick(10);
    check("s2_glitch_level", inputVar, 0);
    check("s2_glitch_noevt", evt_valid, 0);
    check("s2_glitch_ovf", overflow, 0);
    raw_input = 1'b1; tick(4); raw_input = 1'b0; tick(12);
    check("s2_pulse_level", inputVar, 0);
    check("s2_pulse_evt", evt_valid, 1);
    check("s2_pulse_src", evt_src, 1);
    pop_one();

    // Falling edge gives no event; simultaneous rises queue flip first.
    raw_flip = 1'b0; tick(10);
    check("s3_fall_level", flip, 0);
    check("s3_fall_noevt", evt_valid, 0);
    raw_flip = 1'b1; raw_input = 1'b1; tick(8);
    check("s3_head0", evt_src, 0);
    check("s3_valid0", evt_valid, 1);
    check("s3_ovf", overflow, 0);
    pop_one();
    check("s3_head1", evt_src, 1);
    check("s3_valid1", evt_valid, 1);
    pop_one();
    check("s3_empty", evt_valid, 0);

    // Third event into a full queue is dropped; overflow sticks.
    raw_flip = 1'b0; raw_input = 1'b0; tick(10);
    raw_flip = 1'b1; tick(8);
    raw_input = 1'b1; tick(8);
    raw_flip = 1'b0; tick(8);
    raw_flip = 1'b1; tick(8);
    check("s4_ovf", overflow, 1);
    check("s4_head0", evt_src, 0);
    pop_one();
    check("s4_head1", evt_src, 1);
    check("s4_valid1", evt_valid, 1);
    pop_one();
    check("s4_drained", evt_valid, 0);
    tick(5);
    check("s4_ovf_sticky", overflow, 1);

    // Reset in the middle of settling; input held high re-debounces from scratch.
    raw_flip = 1'b0; raw_input = 1'b0; reset = 1'b1; tick();
    reset = 1'b0; raw_flip = 1'b1; tick(5);
    reset = 1'b1; tick();
    check("s5_flip", flip, 0);
    check("s5_inputVar", inputVar, 0);
    check("s5_valid", evt_valid, 0);
    check("s5_src", evt_src, 0);
    check("s5_ovf", overflow, 0);
    reset = 1'b0;
    edges_until_flip(k);
    check("s5_latency", k, 6);
    tick();
    check("s5_valid_after", evt_valid, 1);
    check("s5_src_after", evt_src, 0);
    pop_one();

    // Full queue, pop and push on the same edge.
    raw_input = 1'b1; tick(8);
    raw_flip = 1'b0; tick(8);
    raw_flip = 1'b1; tick(8);
    raw_input = 1'b0; tick(8);
    raw_input = 1'b1; tick(6);
    check("s6_level", inputVar, 1);
    check("s6_head_before", evt_src, 1);
    pop_one();
    check("s6_valid", evt_valid, 1);
    check("s6_head_after", evt_src, 0);
    check("s6_ovf", overflow, 0);
    pop_one();
    check("s6_new_evt", evt_src, 1);
    check("s6_new_valid", evt_valid, 1);
    pop_one();
    check("s6_empty", evt_valid, 0);

    // Random bouncing, random consumer, occasional reset.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 99) < 8) raw_flip = ~raw_flip;
      if ($urandom_range(0, 99) < 8) raw_input = ~raw_input;
      evt_ready = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 999) == 0);
      tick();
    end
    reset = 1'b0; evt_ready = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
